aes_round_ctrl: RTL and testbench

- Parametrised round sequencer for the AES datapath. Successor of the fixed AES-128 controller.
- Supports 128/192/256-bit key lengths (10/12/14 rounds) and replaces the edge-detected start with a valid/ready handshake. Adds a held result-valid with backpressure, a synchronous abort and a reserved-mode error pulse.
- Drives the round-key expansion and state-update registers of the datapath.

---
 rtl/aes_round_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_aes_round_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: runs 10/12/14 rounds per block and strobes the round-key and state registers.
// Latency: accept at T -> round 1 at T+1, last_round at T+Nr, out_valid from T+Nr+1 (block period >= Nr+2).
// Backpressure: in_ready only in IDLE; out_valid is held in DONE until out_ready; abort cancels at any point.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   block request handshake; key_len and decrypt are sampled on accept
//   key_len             00=AES-128 (Nr=10), 01=AES-192 (Nr=12), 10=AES-256 (Nr=14), 11=reserved
//   decrypt             inverse-cipher request (honoured only with AES_DEC_EN)
//   abort               synchronous cancel of the running block; blocks accept in IDLE
//   load                accept cycle: datapath captures block and key
//   key_update          round key advances this cycle
//   state_update        state register updates this cycle
//   last_round          final round (datapath skips MixColumns)
//   round_cnt           current round index, 0 outside rounds
//   rcon                round constant for the current round, 0 outside rounds
//   dec_active          running block is a decryption
//   out_valid/out_ready result handshake
//   err                 one-cycle pulse when a request with an unsupported key length is consumed
//
// Build option: define AES_DEC_EN to support decryption. Without it decrypt is ignored,
// dec_active is tied low and every block runs as an encryption.

module aes_round_ctrl #(
    parameter int MAX_NR = 14,  // largest supported round count (10, 12 or 14)
    parameter int CNT_W  = 4    // round counter width, 2**CNT_W must exceed MAX_NR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       key_len,
    input  logic             decrypt,
    input  logic             abort,
    output logic             load,
    output logic             key_update,
    output logic             state_update,
    output logic             last_round,
    output logic [CNT_W-1:0] round_cnt,
    output logic [7:0]       rcon,
    output logic             dec_active,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] nr_q;
    logic [CNT_W-1:0] nr_req;
    logic             req_legal;
    logic             accept;
    logic             start;
    logic             final_round;
    logic             dec_q;
    logic [CNT_W:0]   rc_idx;

    // Decode the requested key length into a round count. A length whose
    // round count exceeds what this instance was built for is rejected just
    // like the reserved encoding.
    always_comb begin
        nr_req    = '0;
        req_legal = 1'b0;
        case (key_len)
            2'b00: begin
                nr_req    = CNT_W'(10);
                req_legal = (MAX_NR >= 10);
            end
            2'b01: begin
                nr_req    = CNT_W'(12);
                req_legal = (MAX_NR >= 12);
            end
            2'b10: begin
                nr_req    = CNT_W'(14);
                req_legal = (MAX_NR >= 14);
            end
            default: begin
                nr_req    = '0;
                req_legal = 1'b0;
            end
        endcase
    end

    // Abort outranks a new request, so in_ready is withdrawn while it is high.
    assign in_ready    = (state_q == IDLE) && !abort;
    assign accept      = in_valid && in_ready;
    assign start       = accept && req_legal;
    assign final_round = (state_q == RUN) && (round_cnt == nr_q);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (final_round) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Round counter and per-block configuration
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_cnt <= '0;
        end else begin
            case (state_q)
                IDLE:    round_cnt <= start ? CNT_W'(1) : '0;
                RUN:     round_cnt <= (abort || final_round) ? '0 : round_cnt + CNT_W'(1);
                default: round_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nr_q <= '0;
        end else if (start) begin
            nr_q <= nr_req;
        end
    end

`ifdef AES_DEC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= 1'b0;
        end else if (start) begin
            dec_q <= decrypt;
        end
    end
`else
    // Encrypt-only build: the direction flag is a constant and decrypt is unused.
    logic unused_decrypt;
    assign unused_decrypt = decrypt;
    assign dec_q          = 1'b0;
`endif

    // Decryption walks the key schedule backwards, so the constant index
    // mirrors the round index within 1..Nr. One extra bit keeps the
    // subtraction from wrapping.
    always_comb begin
        if (dec_q) begin
            rc_idx = {1'b0, nr_q} + (CNT_W + 1)'(1) - {1'b0, round_cnt};
        end else begin
            rc_idx = {1'b0, round_cnt};
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        load         = start;
        key_update   = start || (state_q == RUN);
        state_update = (state_q == RUN);
        last_round   = final_round;
        out_valid    = (state_q == DONE);
        err          = accept && !req_legal;
        dec_active   = dec_q && ((state_q == RUN) || (state_q == DONE));

        // Only the first ten rounds use a table constant; the 192/256 key
        // expander derives its own schedule beyond that and sees 00.
        rcon = 8'h00;
        if (state_q == RUN) begin
            case (int'(rc_idx))
                1:       rcon = 8'h01;
                2:       rcon = 8'h02;
                3:       rcon = 8'h04;
                4:       rcon = 8'h08;
                5:       rcon = 8'h10;
                6:       rcon = 8'h20;
                7:       rcon = 8'h40;
                8:       rcon = 8'h80;
                9:       rcon = 8'h1B;
                10:      rcon = 8'h36;
                default: rcon = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
`timescale 1ns/1ps
module tb_aes_round_ctrl;

    localparam int CNT_W = 4;
`ifdef AES_DEC_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_valid10;
    logic [1:0]       key_len;
    logic             decrypt;
    logic             abort;
    logic             out_ready;

    logic             in_ready, load, key_update, state_update, last_round;
    logic [CNT_W-1:0] round_cnt;
    logic [7:0]       rcon;
    logic             dec_active, out_valid, err;

    logic             in_ready10, load10, key_update10, state_update10, last_round10;
    logic [CNT_W-1:0] round_cnt10;
    logic [7:0]       rcon10;
    logic             dec_active10, out_valid10, err10;

    int checks = 0;
    int errors = 0;

    // Round constants of the AES key schedule, index 0 unused.
    logic [7:0] rc_tab [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    always #5 clk = ~clk;

    aes_round_ctrl #(.MAX_NR(14), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .key_len(key_len), .decrypt(decrypt), .abort(abort), .load(load),
        .key_update(key_update), .state_update(state_update), .last_round(last_round),
        .round_cnt(round_cnt), .rcon(rcon), .dec_active(dec_active),
        .out_valid(out_valid), .out_ready(out_ready), .err(err)
    );

    // AES-128-only build, used to see longer keys rejected.
    aes_round_ctrl #(.MAX_NR(10), .CNT_W(CNT_W)) dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid10), .in_ready(in_ready10),
        .key_len(key_len), .decrypt(decrypt), .abort(abort), .load(load10),
        .key_update(key_update10), .state_update(state_update10), .last_round(last_round10),
        .round_cnt(round_cnt10), .rcon(rcon10), .dec_active(dec_active10),
        .out_valid(out_valid10), .out_ready(out_ready), .err(err10)
    );

    // Observed output snapshot:
    // {in_ready, load, key_update, state_update, last_round, round_cnt, rcon, dec_active, out_valid, err}
    logic [19:0] obs, obs10;
    assign obs   = {in_ready, load, key_update, state_update, last_round, round_cnt,
                    rcon, dec_active, out_valid, err};
    assign obs10 = {in_ready10, load10, key_update10, state_update10, last_round10, round_cnt10,
                    rcon10, dec_active10, out_valid10, err10};

    function automatic logic [19:0] ev(bit ir, bit ld, bit ku, bit su, bit lr, int rc,
                                       logic [7:0] rcn, bit da, bit ov, bit er);
        return {ir, ld, ku, su, lr, 4'(rc), rcn, da, ov, er};
    endfunction

    // One complete block driven from accept to handshake, every cycle compared
    // with the expected outputs. abort_at>0 cancels during that round; hold is
    // the number of DONE cycles with out_ready low; gap adds an idle cycle after.
    task automatic run_block(input int kl, input bit dec, input int hold,
                             input int abort_at, input bit gap, input string tag);
        int nr;
        bit de;
        int ku_n;
        int su_n;
        logic [7:0] rq[$];
        logic [19:0] e;
        nr   = 10 + 2 * kl;
        de   = dec && DEC_EN;
        ku_n = 0;
        su_n = 0;
        rq   = {};
        for (int r = 1; r <= nr; r++) rq.push_back(r <= 10 ? rc_tab[r] : 8'h00);
        if (de) rq.reverse();

        @(negedge clk);
        in_valid = 1'b1; key_len = 2'(kl); decrypt = dec; abort = 1'b0; out_ready = 1'b0;
        #1;
        e = ev(1, 1, 1, 0, 0, 0, 8'h00, 0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL %s accept: got %h expected %h", tag, obs, e);
        end
        ku_n += int'(key_update);

        for (int r = 1; r <= nr; r++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            key_len  = 2'($urandom_range(0, 3));
            decrypt  = 1'($urandom_range(0, 1));
            abort    = (r == abort_at);
            #1;
            e = ev(0, 0, 1, 1, r == nr, r, rq[r-1], de, 0, 0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s round %0d: got %h expected %h", tag, r, obs, e);
            end
            ku_n += int'(key_update);
            su_n += int'(state_update);
            if (r == abort_at) begin
                @(negedge clk);
                in_valid = 1'b0; abort = 1'b0;
                #1;
                e = ev(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL %s after abort: got %h expected %h", tag, obs, e);
                end
                return;
            end
        end

        for (int c = 0; c <= hold; c++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            key_len   = 2'($urandom_range(0, 3));
            abort     = 1'b0;
            out_ready = (c == hold);
            #1;
            e = ev(0, 0, 0, 0, 0, 0, 8'h00, de, 1, 0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s done cycle %0d: got %h expected %h", tag, c, obs, e);
            end
        end

        checks++;
        if (ku_n != nr + 1 || su_n != nr) begin
            errors++;
            $display("FAIL %s strobe count: key_update %0d state_update %0d expected %0d %0d",
                     tag, ku_n, su_n, nr + 1, nr);
        end

        if (gap) begin
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
            #1;
            e = ev(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s idle after handshake: got %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic test_reset();
        logic [19:0] e;
        rst_n = 1'b0; in_valid = 1'b0; in_valid10 = 1'b0; key_len = 2'b00;
        decrypt = 1'b0; abort = 1'b0; out_ready = 1'b0;
        #1;
        e = ev(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset: got %h expected %h", obs, e);
        end
        checks++;
        if (obs10 !== e) begin
            errors++;
            $display("FAIL reset dut10: got %h expected %h", obs10, e);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_enc128();
        run_block(0, 0, 0, 0, 1, "enc128");
    endtask

    task automatic test_enc256_backpressure();
        run_block(2, 0, 5, 0, 1, "enc256_hold");
        run_block(1, 0, 2, 0, 1, "enc192");
    endtask

    task automatic test_decrypt();
        run_block(0, 1, 1, 0, 1, "dec128");
        run_block(2, 1, 0, 0, 1, "dec256");
    endtask

    task automatic test_reject();
        logic [19:0] e;
        // Reserved key length on the full build.
        @(negedge clk);
        in_valid = 1'b1; key_len = 2'b11;
        #1;
        e = ev(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reject reserved: got %h expected %h", obs, e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        e = ev(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reject reserved stays idle: got %h expected %h", obs, e);
        end
        // 192/256/reserved on the AES-128-only build.
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            in_valid10 = 1'b1; key_len = 2'(k);
            #1;
            e = ev(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1);
            checks++;
            if (obs10 !== e) begin
                errors++;
                $display("FAIL reject max_nr10 key_len %0d: got %h expected %h", k, obs10, e);
            end
            @(negedge clk);
            in_valid10 = 1'b0;
            #1;
            e = ev(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
            checks++;
            if (obs10 !== e) begin
                errors++;
                $display("FAIL reject max_nr10 idle key_len %0d: got %h expected %h", k, obs10, e);
            end
        end
    endtask

    task automatic test_abort();
        logic [19:0] e;
        run_block(0, 0, 0, 5, 0, "abort_r5");
        run_block(0, 0, 0, 0, 1, "after_abort");
        // Abort together with a request in IDLE: nothing is accepted.
        @(negedge clk);
        in_valid = 1'b1; key_len = 2'b00; abort = 1'b1;
        #1;
        e = ev(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL abort in idle: got %h expected %h", obs, e);
        end
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0;
        #1;
        e = ev(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL abort in idle no accept: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_async_reset();
        logic [19:0] e;
        @(negedge clk);
        in_valid = 1'b1; key_len = 2'b00; decrypt = 1'b0; abort = 1'b0; out_ready = 1'b0;
        for (int r = 1; r <= 7; r++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        #1;
        e = ev(0, 0, 1, 1, 0, 7, 8'h40, 0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL async reset round 7: got %h expected %h", obs, e);
        end
        #1;
        rst_n = 1'b0;
        #1;
        e = ev(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL async reset immediate: got %h expected %h", obs, e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_block(0, 0, 1, 0, 1, "post_reset");
    endtask

    task automatic test_back_to_back();
        run_block(0, 1, 0, 0, 0, "b2b_0");
        run_block(1, 0, 0, 0, 0, "b2b_1");
        run_block(0, 0, 0, 0, 1, "b2b_2");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            int kl;
            int ab;
            kl = $urandom_range(0, 2);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10 + 2 * kl) : 0;
            run_block(kl, 1'($urandom_range(0, 1)), $urandom_range(0, 4), ab,
                      1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_enc128();
        test_enc256_backpressure();
        test_decrypt();
        test_reject();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
